// File: rtl/stp16_receiver.sv
// Purpose : recovers frames shifted into a cascaded STP16 LED-driver chain by
//           oversampling the pin-level shift clock, data, latch and output-enable.
// Latency : o_valid registers on the 3rd osc_clk rising edge after the LE pin rises.
// Backpres: a frame is held until o_valid && i_ready. A newer latch overwrites it
//           and pulses o_overrun.
//
// Ports:
//   reset          async active-high reset
//   osc_clk        sampling clock; all state is clocked on its rising edge
//   stp16_clk      serial shift clock pin (asynchronous)
//   stp16_sdi      serial data pin (asynchronous)
//   stp16_le       latch-enable pin (asynchronous)
//   stp16_noe      active-low output-enable pin (asynchronous)
//   o_valid        a captured frame is available
//   i_ready        the consumer accepts the frame
//   o_data         the captured frame; the first serial bit is in o_data[width-1]
//   o_enable       synchronized, inverted stp16_noe
//   o_overrun      one-cycle pulse when an unaccepted frame is overwritten
//   o_frame_error  one-cycle pulse when a latch sees a bit count other than width
//
// Build option: define STP16_RECEIVER_BITCOUNT_CHECK_EN to reject latches whose
// bit count is not width. In that case o_frame_error pulses and o_data/o_valid
// are not updated. Without the define every latch is delivered and
// o_frame_error is tied to 0.

module stp16_receiver #(
  parameter int width = 64
) (
  input  logic             reset,
  input  logic             osc_clk,
  input  logic             stp16_clk,
  input  logic             stp16_sdi,
  input  logic             stp16_le,
  input  logic             stp16_noe,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [width-1:0] o_data,
  output logic             o_enable,
  output logic             o_overrun,
  output logic             o_frame_error
);

  // The counter has to reach width+1 so that an over-long frame stays distinct
  // from an exact one.
  localparam int CW = $clog2(width + 2);

  // Two-flop synchronizers; bit [1] is the synchronized value.
  logic [1:0] clk_sync_q;
  logic [1:0] sdi_sync_q;
  logic [1:0] le_sync_q;
  // noe is stored inverted in both stages. With all flops resetting to 0,
  // o_enable is then 0 during reset and never glitches high after release
  // while the pin is high.
  logic [1:0] en_sync_q;

  logic       clk_prev_q;
  logic       le_prev_q;

  // Edge detection stays disarmed for three cycles after reset. During that
  // time the synchronizers and the previous-value flops fill with the real pin
  // levels, so a pin that is already high at release is not seen as a rising edge.
  logic [1:0] arm_q;
  logic       armed;

  logic             clk_rise;
  logic             le_rise;
  logic             accept;
  logic             deliver;

  logic [width-1:0] shift_q, shift_d;
  logic [width-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '0;
      sdi_sync_q <= '0;
      le_sync_q  <= '0;
      en_sync_q  <= '0;
      clk_prev_q <= 1'b0;
      le_prev_q  <= 1'b0;
      arm_q      <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], stp16_clk};
      sdi_sync_q <= {sdi_sync_q[0], stp16_sdi};
      le_sync_q  <= {le_sync_q[0], stp16_le};
      en_sync_q  <= {en_sync_q[0], ~stp16_noe};
      clk_prev_q <= clk_sync_q[1];
      le_prev_q  <= le_sync_q[1];
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
    end
  end

  assign armed    = (arm_q == 2'd3);
  assign clk_rise = armed & clk_sync_q[1] & ~clk_prev_q;
  assign le_rise  = armed & le_sync_q[1] & ~le_prev_q;
  assign accept   = valid_q & i_ready;

  // Shift and count. When a shift and a latch land in the same cycle, the
  // latch sees the post-shift register and the count includes that bit.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clk_rise) begin
      shift_d = {shift_q[width-2:0], sdi_sync_q[1]};
      if (cnt_q != CW'(width + 1)) cnt_d = cnt_q + CW'(1);
    end
    if (le_rise) cnt_d = '0;
  end

`ifdef STP16_RECEIVER_BITCOUNT_CHECK_EN
  logic frame_ok;
  logic frame_error_q;

  // The post-shift count is checked, so a bit that coincides with the latch
  // is counted.
  always_comb begin
    frame_ok = 1'b0;
    if (clk_rise) frame_ok = ((cnt_q + CW'(1)) == CW'(width));
    else          frame_ok = (cnt_q == CW'(width));
  end

  assign deliver = le_rise & frame_ok;

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) frame_error_q <= 1'b0;
    else       frame_error_q <= le_rise & ~frame_ok;
  end

  assign o_frame_error = frame_error_q;
`else
  assign deliver       = le_rise;
  assign o_frame_error = 1'b0;
`endif

  // Output holding register. A delivery in the same cycle as an accepting
  // handshake replaces the accepted frame, so that case is not an overrun.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (accept) valid_d = 1'b0;
    if (deliver) begin
      data_d    = shift_d;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~i_ready;
    end
  end

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_overrun = overrun_q;
  assign o_enable  = en_sync_q[1];

endmodule

// File: tb/tb_stp16_receiver.sv
// Purpose : directed and randomized checks of stp16_receiver at width=64,
//           compared against a bit-queue reference model.
// Latency : inputs are driven and outputs sampled 1 time unit after each osc_clk rise.
// Backpres: i_ready is held low except for explicit consume and handshake steps.

module tb_stp16_receiver;

  localparam int W = 64;

`ifdef STP16_RECEIVER_BITCOUNT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         reset, osc_clk, stp16_clk, stp16_sdi, stp16_le, stp16_noe, i_ready;
  logic         o_valid, o_enable, o_overrun, o_frame_error;
  logic [W-1:0] o_data;

  int tests = 0;
  int fails = 0;

  // Reference model: every bit shifted since reset, bits since the last latch,
  // and the expected output holding register.
  bit           q[$];
  int           cnt;
  bit           m_valid;
  logic [W-1:0] m_data;

  stp16_receiver #(.width(W)) dut (
    .reset         (reset),
    .osc_clk       (osc_clk),
    .stp16_clk     (stp16_clk),
    .stp16_sdi     (stp16_sdi),
    .stp16_le      (stp16_le),
    .stp16_noe     (stp16_noe),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data        (o_data),
    .o_enable      (o_enable),
    .o_overrun     (o_overrun),
    .o_frame_error (o_frame_error)
  );

  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // The frame is the last W shifted bits. The oldest bit goes to the MSB, and
  // positions before the first bit after reset read as 0.
  function automatic logic [W-1:0] frame_exp();
    logic [W-1:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < W; i++) begin
      idx = q.size() - W + i;
      if (idx >= 0) r[W-1-i] = q[idx];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    stp16_sdi = b;
    repeat (3) tick();
    stp16_clk = 1'b1;
    q.push_back(b);
    cnt++;
    repeat (3) tick();
    stp16_clk = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[n-1-i]);
  endtask

  // Pulse LE and check the result. With with_bit set, one final bit is shifted
  // with its clock edge in the same cycle as the LE edge. With rdy set, i_ready
  // is high on the edge where the latch takes effect.
  task automatic do_latch(input bit rdy, input bit with_bit, input bit b);
    bit ok, exp_ovr, exp_ferr;
    if (with_bit) begin
      stp16_sdi = b;
      repeat (3) tick();
      stp16_clk = 1'b1;
      q.push_back(b);
      cnt++;
    end
    stp16_le = 1'b1;
    tick();
    tick();
    chk1("hold_valid_before_latch", o_valid, m_valid);
    chk("hold_data_before_latch", o_data, m_data);
    if (rdy) i_ready = 1'b1;
    tick();
    i_ready  = 1'b0;
    ok       = !CHK || (cnt == W);
    exp_ovr  = ok && m_valid && !rdy;
    exp_ferr = CHK && (cnt != W);
    if (ok) begin
      m_data  = frame_exp();
      m_valid = 1'b1;
    end else if (rdy && m_valid) begin
      m_valid = 1'b0;
    end
    cnt = 0;
    chk1("latch_valid", o_valid, m_valid);
    chk("latch_data", o_data, m_data);
    chk1("latch_overrun", o_overrun, exp_ovr);
    chk1("latch_frame_error", o_frame_error, exp_ferr);
    tick();
    chk1("overrun_one_cycle", o_overrun, 1'b0);
    chk1("frame_error_one_cycle", o_frame_error, 1'b0);
    stp16_le  = 1'b0;
    stp16_clk = 1'b0;
    repeat (3) tick();
  endtask

  task automatic consume();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    m_valid = 1'b0;
    chk1("consume_clears_valid", o_valid, m_valid);
    chk("consume_keeps_data", o_data, m_data);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    chk1("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_data, '0);
    chk1("rst_enable", o_enable, 1'b0);
    chk1("rst_overrun", o_overrun, 1'b0);
    chk1("rst_frame_error", o_frame_error, 1'b0);
    tick();
    reset = 1'b0;
    q.delete();
    cnt     = 0;
    m_valid = 1'b0;
    m_data  = '0;
    repeat (4) tick();
  endtask

  initial begin
    logic [W-1:0] x;
    int           n;
    bit           r;

    reset     = 1'b1;
    stp16_clk = 1'b0;
    stp16_sdi = 1'b0;
    stp16_le  = 1'b0;
    stp16_noe = 1'b1;
    i_ready   = 1'b0;
    q.delete();
    cnt     = 0;
    m_valid = 1'b0;
    m_data  = '0;
    repeat (2) tick();
    do_reset();

    // MSB-first frame with 3-cycle latch latency.
    send_word(64'hF0F0_0000_FFFF_0001, W);
    do_latch(1'b0, 1'b0, 1'b0);
    chk("frame_f0f0", o_data, 64'hF0F0_0000_FFFF_0001);
    consume();

    // Overrun: two frames with no handshake, then accept.
    send_word(64'h1, W);
    do_latch(1'b0, 1'b0, 1'b0);
    send_word(64'h2, W);
    do_latch(1'b0, 1'b0, 1'b0);
    chk("overrun_data", o_data, 64'h2);
    consume();

    // o_enable follows noe inverted after two cycles; capture unaffected.
    stp16_noe = 1'b0;
    tick();
    chk1("enable_after_1", o_enable, 1'b0);
    tick();
    chk1("enable_after_2", o_enable, 1'b1);
    x = {$urandom, $urandom};
    send_word(x, W);
    do_latch(1'b0, 1'b0, 1'b0);
    chk("frame_with_enable", o_data, x);
    consume();
    stp16_noe = 1'b1;
    repeat (2) tick();
    chk1("enable_drop", o_enable, 1'b0);

    // Short frame: 63 bits.
    send_word({$urandom, $urandom}, W - 1);
    do_latch(1'b0, 1'b0, 1'b0);
    if (m_valid) consume();

    // Last bit clock and LE in the same cycle.
    x = {$urandom, $urandom};
    for (int i = 0; i < W - 1; i++) send_bit(x[W-1-i]);
    do_latch(1'b0, 1'b1, x[0]);
    chk("same_cycle_clk_le", o_data, x);
    consume();

    // Latch coinciding with an accepting handshake.
    send_word({$urandom, $urandom}, W);
    do_latch(1'b0, 1'b0, 1'b0);
    x = {$urandom, $urandom};
    send_word(x, W);
    do_latch(1'b1, 1'b0, 1'b0);
    chk("handshake_latch_data", o_data, x);
    consume();

    // Reset mid-frame, with noe low so the reset value of o_enable is meaningful.
    stp16_noe = 1'b0;
    send_word(64'hFFFFF, 20);
    do_reset();
    send_word(64'hA5A5_A5A5_A5A5_A5A5, W);
    do_latch(1'b0, 1'b0, 1'b0);
    chk("after_reset_frame", o_data, 64'hA5A5_A5A5_A5A5_A5A5);
    consume();

    // Reset releases while the clk and LE pins are high: no spurious edges.
    reset     = 1'b1;
    stp16_clk = 1'b1;
    stp16_le  = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    cnt     = 0;
    m_valid = 1'b0;
    m_data  = '0;
    repeat (6) tick();
    chk1("no_spurious_le", o_valid, 1'b0);
    stp16_clk = 1'b0;
    stp16_le  = 1'b0;
    repeat (3) tick();
    x = {$urandom, $urandom};
    send_word(x, W);
    do_latch(1'b0, 1'b0, 1'b0);
    chk("no_spurious_clk", o_data, x);
    consume();

    // Randomized frames of varying length with random handshakes.
    for (int k = 0; k < 8; k++) begin
      n = ($urandom_range(0, 3) == 0) ? W - 2 + $urandom_range(0, 4) : W;
      for (int i = 0; i < n; i++) send_bit(1'($urandom));
      r = 1'($urandom);
      do_latch(r, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) consume();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
